// File: rtl/regdump_pkg.sv
// Shared types and helpers for the register-file dump reader.
// State SUM is only reachable when REGDUMP_CHECKSUM_EN is defined.
package regdump_pkg;

    localparam int DEF_NREGS = 32;
    localparam int DEF_AW    = 5;
    localparam int DEF_DW    = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        SUM  = 2'd2
    } state_t;

    // Number of words in a wrapping first..last range.
    function automatic int unsigned word_count(input int unsigned first,
                                               input int unsigned last,
                                               input int unsigned nregs);
        return ((last + nregs - first) % nregs) + 1;
    endfunction

endpackage

// File: rtl/regfile_dump_reader_if.sv
// Valid/ready output stream of the register-file dump reader.
// master drives the word, slave returns out_ready.
interface regfile_dump_reader_if #(
    parameter int AW = 5,
    parameter int DW = 32
);
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_addr;
    logic          out_last;
    logic          out_is_sum;

    modport master (
        output out_valid, out_data, out_addr, out_last, out_is_sum,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_data, out_addr, out_last, out_is_sum,
        output out_ready
    );
endinterface

// File: rtl/regdump_out_stage.sv
// Single-entry valid/ready output register for the dump stream.
// Accepts a new word whenever it is empty or its word leaves this cycle.
module regdump_out_stage #(
    parameter int AW = 5,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          load,
    input  logic [DW-1:0] in_data,
    input  logic [AW-1:0] in_addr,
    input  logic          in_last,
    input  logic          in_is_sum,
    output logic          can_load,
    output logic          valid,
    input  logic          ready,
    output logic [DW-1:0] data,
    output logic [AW-1:0] addr,
    output logic          last,
    output logic          is_sum
);

    assign can_load = !valid || ready;

    // output stage boundary
    always_ff @(posedge clk) begin
        if (clr) begin
            valid  <= 1'b0;
            data   <= '0;
            addr   <= '0;
            last   <= 1'b0;
            is_sum <= 1'b0;
        end else if (load && can_load) begin
            valid  <= 1'b1;
            data   <= in_data;
            addr   <= in_addr;
            last   <= in_last;
            is_sum <= in_is_sum;
        end else if (ready) begin
            valid  <= 1'b0;
        end
    end

endmodule

// File: rtl/regfile_dump_reader.sv
// Register-file dump engine: walks first..last (wrapping) on a read port and streams words out.
// Define REGDUMP_CHECKSUM_EN to append a mod-2^DW checksum word after the register words.
module regfile_dump_reader
    import regdump_pkg::*;
#(
    parameter int NREGS = DEF_NREGS,
    parameter int AW    = DEF_AW,
    parameter int DW    = DEF_DW
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  start,
    input  logic [AW-1:0]         first_addr,
    input  logic [AW-1:0]         last_addr,
    output logic [AW-1:0]         rf_addr,
    input  logic [DW-1:0]         rf_data,
    regfile_dump_reader_if.master dump,
    output logic                  busy,
    output logic                  done
);

    localparam int CW = AW + 1;

    state_t        state, state_nxt;
    logic [AW-1:0] ptr;
    logic [CW-1:0] rem;
    logic          accept_start, final_acc, pending, can_load, fetch;
    logic          ld, ld_last, ld_is_sum;
    logic [DW-1:0] ld_data;
    logic [AW-1:0] ld_addr;

    // start is ignored during the done cycle so a dump never restarts on its own pulse
    assign accept_start = (state == IDLE) && start && !done;
    assign final_acc    = dump.out_valid && dump.out_ready && dump.out_last;
    assign pending      = (state == RUN) && (rem != '0);
    assign fetch        = pending && can_load;
    assign busy         = (state != IDLE);

    always_ff @(posedge clk) begin
        if (clr) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept_start) state_nxt = RUN;
`ifdef REGDUMP_CHECKSUM_EN
            RUN:  if (fetch && rem == CW'(1)) state_nxt = SUM;
            SUM:  if (final_acc) state_nxt = IDLE;
`else
            RUN:  if (final_acc) state_nxt = IDLE;
`endif
            default: state_nxt = IDLE;
        endcase
    end

`ifdef REGDUMP_CHECKSUM_EN
    logic [DW-1:0] acc;

    always_ff @(posedge clk) begin
        if (clr || accept_start) acc <= '0;
        else if (fetch)          acc <= acc + rf_data;
    end
`endif

    always_comb begin
        rf_addr   = '0;
        ld        = 1'b0;
        ld_data   = rf_data;
        ld_addr   = ptr;
        ld_last   = 1'b0;
        ld_is_sum = 1'b0;
        case (state)
            RUN: begin
                if (pending) begin
                    rf_addr = ptr;
                    ld      = 1'b1;
                end
`ifndef REGDUMP_CHECKSUM_EN
                ld_last = (rem == CW'(1));
`endif
            end
`ifdef REGDUMP_CHECKSUM_EN
            SUM: begin
                // load the checksum once; it is held until accepted
                ld        = !(dump.out_valid && dump.out_is_sum);
                ld_data   = acc;
                ld_addr   = '0;
                ld_last   = 1'b1;
                ld_is_sum = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            ptr  <= '0;
            rem  <= '0;
            done <= 1'b0;
        end else begin
            done <= final_acc;
            if (accept_start) begin
                ptr <= first_addr;
                rem <= CW'(word_count(int'(first_addr), int'(last_addr), NREGS));
            end else if (fetch) begin
                ptr <= ptr + AW'(1);
                rem <= rem - CW'(1);
            end
        end
    end

    regdump_out_stage #(.AW(AW), .DW(DW)) u_out (
        .clk       (clk),
        .clr       (clr),
        .load      (ld),
        .in_data   (ld_data),
        .in_addr   (ld_addr),
        .in_last   (ld_last),
        .in_is_sum (ld_is_sum),
        .can_load  (can_load),
        .valid     (dump.out_valid),
        .ready     (dump.out_ready),
        .data      (dump.out_data),
        .addr      (dump.out_addr),
        .last      (dump.out_last),
        .is_sum    (dump.out_is_sum)
    );

endmodule

// File: doc/regfile_dump_reader.md
# regfile_dump_reader

Sequential read-out engine for the 32×32 processor register file. On a `start` pulse it walks a contiguous, possibly wrapping range of register addresses on one register-file read port and streams each word out over a valid/ready interface, with a `done` pulse at the end. It sits beside the register file in the core and feeds the debug/trace path. It uses only a spare combinational read port and never writes the register file.

## Interface
Parameters:
- `NREGS`, 32: number of architectural registers; must be a power of two.
- `AW`, 5: address width, log2(NREGS).
- `DW`, 32: data width.

Ports:
- `clk`  in  1: single clock; all state changes on the rising edge.
- `clr`  in  1: reset, synchronous, active-high.
- `start`  in  1: one-cycle request to begin a dump; sampled only in IDLE.
- `first_addr`  in  AW: first register to dump; latched on an accepted `start`.
- `last_addr`  in  AW: last register to dump; latched on an accepted `start`.
- `rf_addr`  out  AW: address driven to a register-file read port.
- `rf_data`  in  DW: combinational read data for `rf_addr`.
- `out_valid`  out  1: `out_data`, `out_addr` and `out_last` are valid.
- `out_ready`  in  1: downstream accepts the word this cycle.
- `out_data`  out  DW: register value.
- `out_addr`  out  AW: register index of `out_data`.
- `out_last`  out  1: final word of this dump.
- `out_is_sum`  out  1: the current word is the checksum word (see Configuration).
- `busy`  out  1: high from the cycle after an accepted `start` until `done`.
- `done`  out  1: one-cycle pulse after the final word is accepted.

## Operation
- States: IDLE, RUN, SUM (SUM exists only with the macro).
- IDLE: `busy`=0. If `start` is high, latch `first_addr`/`last_addr` and set `ptr`=`first_addr`, then go to RUN.
- Word count N = ((`last_addr` − `first_addr`) mod NREGS) + 1.
  - `first_addr` = `last_addr` dumps exactly one register.
  - `last_addr` < `first_addr` wraps 31→0.
  - A full dump is first=0, last=31.
- RUN fetch:
  - `rf_addr` = `ptr` while a fetch is pending.
  - A fetch fires when (!`out_valid` || `out_ready`). It loads the output register with `rf_data` and `ptr`, then `ptr` ← `ptr`+1 mod NREGS.
  - No fetch fires after the last address has been fetched.
- Output register holds `out_data`/`out_addr`/`out_last` stable while `out_valid` && !`out_ready`.
- `out_last` = 1 on word N; with the macro it is 1 on the checksum word instead.
- Acceptance of the final word (`out_valid` && `out_ready` && `out_last`):
  - Next cycle: `out_valid`=0, `busy`=0, `done`=1 for one cycle.
  - State returns to IDLE.
- `start` while `busy` is ignored. No queuing.
- Register-file writes during a dump: each word reflects the register-file contents at the cycle its address was presented, i.e. the value before any write committing on that edge.
- `rf_addr` = 0 in IDLE.

## Timing
- Reset: all outputs 0, state IDLE, `ptr`=0. Takes effect on the first edge with `clr`=1 and overrides a simultaneous `start`.
- `clr` mid-dump aborts immediately. No `done` is produced and the partial stream is discarded; `out_valid` is 0 the following cycle.
- `start` accepted at edge T:
  - `busy`=1 and `rf_addr`=first from T+1.
  - First `out_valid` at T+2.
- With `out_ready` held high: one word per cycle. The last register word is valid at T+N+1 and `done` pulses at T+N+2.
- Back-pressure: no word is dropped or duplicated, and `rf_addr` holds while stalled.
- A `start` in the same cycle as `done` is ignored. A new dump may start from the cycle after `done`.

## Configuration
- `REGDUMP_CHECKSUM_EN` defined:
  - After word N, state SUM emits one extra word: `out_data` = sum of all N emitted register words mod 2^32, `out_addr`=0, `out_is_sum`=1, `out_last`=1.
  - The sum accumulates on each fetch and clears on an accepted `start`.
  - `done` follows acceptance of the checksum word.
- `REGDUMP_CHECKSUM_EN` undefined: no SUM state and no accumulator. `out_is_sum` is tied 0 and the stream is exactly N words.

## Structure
- Package `regdump_pkg`:
  - State enum (IDLE, RUN, SUM).
  - Default constants NREGS=32, AW=5, DW=32.
  - Function computing N from first/last.
- Sub-module `regdump_out_stage`: single-entry valid/ready output register holding data, addr, last and is_sum flags; load on (!valid || ready).
- Top holds the FSM, pointer, remaining-count and checksum accumulator.

## Test plan
- Full dump, ready=1, registers preloaded with value 0x100+i: `start` first=0 last=31 → 32 words, addrs 0..31, data 0x100..0x11F, `out_last` on addr 31, `done` exactly 34 cycles after the `start` edge.
- Wrap: first=30, last=1 → addrs 30, 31, 0, 1; `out_last` on 1; 4 words.
- Single register, first=last=7, reg7=0xDEADBEEF → one word 0xDEADBEEF with `out_last`=1, then `done`.
- Back-pressure: ready toggles 1,0,0,1 during a 4-word dump → outputs stable while stalled, no loss or duplication, order preserved.
- `clr` asserted after 3 of 32 words accepted → `out_valid`/`busy`=0 next cycle, no `done`. A new `start` then dumps from the new first_addr.
- Macro on, regs 1..3 = 1, 2, 0xFFFFFFFF, first=1 last=3 → 4th word 0x00000002 with `out_is_sum`=1 and `out_last`=1.
